app_regrw_tst: RTL and testbench



---
 rtl/app_tst_pkg.sv | 26 ++
 rtl/app_reg_hs.sv | 67 ++++++
 rtl/app_regrw_tst.sv | 147 ++++++++++++++
 tb/tb_app_regrw_tst.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/app_tst_pkg.sv
// Shared types and helpers for the user register read/write self-test.
// Address and pattern helpers are computed wide and truncated by the caller.
package app_tst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrReq,
        StRdReq,
        StDone
    } tst_state_e;

    localparam int unsigned GAP_LEN  = 1;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned HELPER_W = 64;

    function automatic logic [HELPER_W-1:0] reg_byte_addr(input logic [HELPER_W-1:0] base,
                                                          input logic [HELPER_W-1:0] idx);
        return base + (idx << 2);
    endfunction

    function automatic logic [HELPER_W-1:0] reg_pattern(input logic [HELPER_W-1:0] seed,
                                                        input logic [HELPER_W-1:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/app_reg_hs.sv
// Register port handshake: owns req/ack sequencing, the idle gap after each
// access and the ack timeout counter.
module app_reg_hs
    import app_tst_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DATA_W  = 32,
    parameter logic [15:0]       ACK_TMO = 16'd1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              start_wr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              ack,
    output logic              req,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              tmo
);
    localparam int unsigned GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    logic [15:0]      tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Ack wins over a timeout landing in the same cycle.
    assign done  = req & ack;
    assign tmo   = req & ~ack & (tmo_cnt == ACK_TMO - 16'd1);
    assign ready = ~req & (gap_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req     <= 1'b0;
            wr      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else if (abort) begin
            req     <= 1'b0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else if (start) begin
            req     <= 1'b1;
            wr      <= start_wr;
            addr    <= start_addr;
            wdata   <= start_wdata;
            tmo_cnt <= '0;
        end else if (done || tmo) begin
            req     <= 1'b0;
            gap_cnt <= GAP_W'(GAP_LEN - 1);
        end else begin
            if (req) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/app_regrw_tst.sv
// User register self-test: on a rising run edge, writes a pattern to REG_NUM
// registers, reads them back and reports busy/done/pass/error/timeout status.
module app_regrw_tst
    import app_tst_pkg::*;
#(
    parameter int unsigned       REG_NUM   = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(32'hA5A5_0000),
    parameter logic [15:0]       ACK_TMO   = 16'd1023
) (
    input  logic              usr_clk,
    input  logic              usr_rst_n,
    input  logic              usr_regrw_run_i,
    output logic              reg_req_o,
    output logic              reg_wr_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic              reg_ack_i,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              tst_busy_o,
    output logic              tst_done_o,
    output logic              tst_pass_o,
    output logic [ERR_W-1:0]  tst_err_cnt_o,
    output logic              tst_tmo_o
);
    localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    tst_state_e       state;
    logic             run_d;
    logic [IDX_W-1:0] idx;
    logic             busy, done, pass, tmo_flag;
    logic [ERR_W-1:0] err_cnt;

    logic             start, active, last;
    logic [IDX_W-1:0] acc_idx;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] pattern;
    logic             hs_start, hs_abort, hs_wr, hs_ready, hs_done, hs_tmo;
    logic             err_inc, tmo_nxt;
    logic [ERR_W-1:0] err_nxt;

    assign start    = usr_regrw_run_i & ~run_d;
    assign active   = (state == StWrReq) || (state == StRdReq);
    assign last     = idx == IDX_W'(REG_NUM - 1);
    // The first write is launched from IDLE before idx has been cleared.
    assign acc_idx  = (state == StIdle) ? '0 : idx;
    assign acc_addr = ADDR_W'(reg_byte_addr(HELPER_W'(ADDR_BASE), HELPER_W'(acc_idx)));
    assign pattern  = DATA_W'(reg_pattern(HELPER_W'(SEED), HELPER_W'(acc_idx)));

    assign hs_start = ((state == StIdle) & start) | (active & usr_regrw_run_i & hs_ready);
    assign hs_abort = active & ~usr_regrw_run_i;
    assign hs_wr    = (state != StRdReq);

    // A timed-out read is one error; its data is never compared.
    assign err_inc = hs_tmo | (hs_done & (state == StRdReq) & (reg_rdata_i != pattern));
    assign err_nxt = (err_inc && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;
    assign tmo_nxt = tmo_flag | hs_tmo;

    app_reg_hs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ACK_TMO(ACK_TMO)
    ) u_hs (
        .clk        (usr_clk),
        .rst_n      (usr_rst_n),
        .start      (hs_start),
        .abort      (hs_abort),
        .start_wr   (hs_wr),
        .start_addr (acc_addr),
        .start_wdata(pattern),
        .ack        (reg_ack_i),
        .req        (reg_req_o),
        .wr         (reg_wr_o),
        .addr       (reg_addr_o),
        .wdata      (reg_wdata_o),
        .ready      (hs_ready),
        .done       (hs_done),
        .tmo        (hs_tmo)
    );

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state    <= StIdle;
            run_d    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            run_d <= usr_regrw_run_i;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StWrReq;
                        idx      <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        tmo_flag <= 1'b0;
                    end
                end
                StWrReq, StRdReq: begin
                    if (!usr_regrw_run_i) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (hs_done || hs_tmo) begin
                        err_cnt  <= err_nxt;
                        tmo_flag <= tmo_nxt;
                        if (!last) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            idx <= '0;
                            if (state == StWrReq) begin
                                state <= StRdReq;
                            end else begin
                                state <= StDone;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_nxt == '0) && !tmo_nxt;
                            end
                        end
                    end
                end
                StDone: begin
                    if (!usr_regrw_run_i) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign tst_busy_o    = busy;
    assign tst_done_o    = done;
    assign tst_pass_o    = pass;
    assign tst_err_cnt_o = err_cnt;
    assign tst_tmo_o     = tmo_flag;

endmodule

// File: tb/tb_app_regrw_tst.sv
// Bench for app_regrw_tst: slave model with per-register faults, access-order
// monitor and an outcome model derived from the configured faults.
module tb_app_regrw_tst;
    localparam int N       = 8;
    localparam int TMO     = 1023;
    localparam int S_N     = 256;
    localparam logic [31:0] SEED_TB = 32'hA5A5_0000;

    logic        clk = 1'b0, rst_n = 1'b1, run = 1'b0, ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        req, wr, busy, done, pass, tmo;
    logic [7:0]  addr, err;
    logic [31:0] wdata;

    logic        s_run = 1'b0, s_ack = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_req, s_wr, s_busy, s_done, s_pass, s_tmo;
    logic [7:0]  s_addr, s_err;
    logic [31:0] s_wdata;

    int n_chk = 0, n_pass = 0;

    logic [31:0] mem [N];
    bit          noack_wr [N], noack_rd [N], corrupt [N];
    int          dly_tab [16];
    bit          spurious;
    int          acc_k, hi_cnt, low_cnt, cur_k;
    bit          in_acc, cur_wr;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;

    always #5 clk = ~clk;

    app_regrw_tst u_dut (
        .usr_clk        (clk),
        .usr_rst_n      (rst_n),
        .usr_regrw_run_i(run),
        .reg_req_o      (req),
        .reg_wr_o       (wr),
        .reg_addr_o     (addr),
        .reg_wdata_o    (wdata),
        .reg_ack_i      (ack),
        .reg_rdata_i    (rdata),
        .tst_busy_o     (busy),
        .tst_done_o     (done),
        .tst_pass_o     (pass),
        .tst_err_cnt_o  (err),
        .tst_tmo_o      (tmo)
    );

    app_regrw_tst #(
        .REG_NUM(S_N),
        .ACK_TMO(16'd4)
    ) u_sat (
        .usr_clk        (clk),
        .usr_rst_n      (rst_n),
        .usr_regrw_run_i(s_run),
        .reg_req_o      (s_req),
        .reg_wr_o       (s_wr),
        .reg_addr_o     (s_addr),
        .reg_wdata_o    (s_wdata),
        .reg_ack_i      (s_ack),
        .reg_rdata_i    (s_rdata),
        .tst_busy_o     (s_busy),
        .tst_done_o     (s_done),
        .tst_pass_o     (s_pass),
        .tst_err_cnt_o  (s_err),
        .tst_tmo_o      (s_tmo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_addr(input int k);
        return 8'((k % N) * 4);
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        return SEED_TB + 32'(k % N);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req, wr, addr, wdata, busy, done, pass, err, tmo});
    endfunction

    // Outcome of a full run from the configured faults; unacked writes leave
    // the cleared memory at 0, so the later read mismatches.
    function automatic int model_err();
        int e = 0;
        for (int i = 0; i < N; i++) begin
            if (noack_wr[i]) e++;
            if (noack_rd[i] || corrupt[i] || noack_wr[i]) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    function automatic bit model_tmo();
        bit t = 0;
        for (int i = 0; i < N; i++) t |= noack_wr[i] | noack_rd[i];
        return t;
    endfunction

    // Slave and monitor for the main DUT.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_acc = 0; ack = 0; low_cnt = 0;
        end else if (req) begin
            if (!in_acc) begin
                in_acc = 1; hi_cnt = 0; cur_k = acc_k; acc_k++;
                cur_wr = wr; cur_addr = addr; cur_wdata = wdata;
                check_val("acc_wr", 64'(wr), 64'(cur_k < N));
                check_val("acc_addr", 64'(addr), 64'(exp_addr(cur_k)));
                if (cur_k < N) check_val("acc_wdata", 64'(wdata), 64'(exp_data(cur_k)));
                if (cur_k > 0) check_val("acc_gap", 64'(low_cnt), 64'd1);
            end else begin
                check_val("acc_stable", 64'({wr, addr, wdata}), 64'({cur_wr, cur_addr, cur_wdata}));
            end
            hi_cnt++;
            low_cnt = 0;
            ack = 0;
            if (hi_cnt == dly_tab[cur_k % 16] &&
                !(cur_wr ? noack_wr[cur_k % N] : noack_rd[cur_k % N])) begin
                ack = 1;
                if (cur_wr) mem[cur_k % N] = wdata;
                else rdata = corrupt[cur_k % N] ? 32'd0 : mem[cur_k % N];
            end
        end else begin
            if (in_acc) begin
                in_acc = 0;
                if (run) begin
                    if (cur_wr ? noack_wr[cur_k % N] : noack_rd[cur_k % N])
                        check_val("req_len_tmo", 64'(hi_cnt), 64'(TMO));
                    else
                        check_val("req_len_ack", 64'(hi_cnt), 64'(dly_tab[cur_k % 16]));
                end
            end
            low_cnt++;
            ack = spurious && ($urandom_range(0, 3) == 0);
            if (ack) rdata = $urandom;
        end
    end

    // Saturation slave: writes never acked, reads acked at once with zero data.
    initial forever begin
        @(negedge clk);
        s_ack = s_req && !s_wr && !s_ack;
    end

    task automatic set_ideal(input int dly);
        for (int i = 0; i < N; i++) begin
            noack_wr[i] = 0; noack_rd[i] = 0; corrupt[i] = 0;
        end
        for (int k = 0; k < 16; k++) dly_tab[k] = dly;
        spurious = 0;
    endtask

    task automatic run_seq(input string tag, input bit hold);
        int b = 0;
        int e_err = model_err();
        bit e_tmo = model_tmo();
        for (int i = 0; i < N; i++) mem[i] = '0;
        @(negedge clk);
        acc_k = 0;
        run = 1;
        @(negedge clk);
        check_val({tag, "_req_rise"}, 64'({req, busy, done}), 64'b110);
        while (!done && b < 20000) begin
            @(negedge clk);
            b++;
        end
        check_val({tag, "_in_time"}, 64'(b < 20000), 64'd1);
        check_val({tag, "_busy_done"}, 64'({busy, done}), 64'b01);
        check_val({tag, "_err"}, 64'(err), 64'(e_err));
        check_val({tag, "_tmo"}, 64'(tmo), 64'(e_tmo));
        check_val({tag, "_pass"}, 64'(pass), 64'(e_err == 0 && !e_tmo));
        check_val({tag, "_accesses"}, 64'(acc_k), 64'(2 * N));
        if (hold) begin
            spurious = 1;
            repeat (100) @(negedge clk);
            check_val({tag, "_hold_acc"}, 64'(acc_k), 64'(2 * N));
            check_val({tag, "_hold_state"}, 64'({req, busy, done, pass, err}),
                      64'({1'b0, 1'b0, 1'b1, 1'b1, 8'd0}));
            spurious = 0;
        end
        run = 0;
        repeat (2) @(negedge clk);
        check_val({tag, "_sticky"}, 64'({busy, done}), 64'b01);
    endtask

    task automatic wait_access(input string tag, input int k);
        int b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while (!(acc_k == k + 1 && req) && b < 2000);
        check_val({tag, "_reached"}, 64'(b < 2000), 64'd1);
    endtask

    task automatic abort_at(input string tag, input int k, input int e_err);
        @(negedge clk);
        acc_k = 0;
        run = 1;
        wait_access(tag, k);
        run = 0;
        @(negedge clk);
        #1;
        check_val({tag, "_dropped"}, 64'({req, busy, done, pass}), 64'b0);
        check_val({tag, "_err_held"}, 64'({err, tmo}), 64'({8'(e_err), 1'b0}));
        @(negedge clk);
    endtask

    initial begin
        int b, wraps;
        logic [7:0] prev;
        set_ideal(2);
        #1 rst_n = 0;
        #2 check_val("reset_outputs", all_outs(), 64'd0);
        check_val("reset_sat", 64'({s_req, s_busy, s_done, s_pass, s_err, s_tmo}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check_val("idle_no_req", 64'({req, busy}), 64'd0);

        set_ideal(2);
        run_seq("ideal", 1);

        set_ideal(2);
        corrupt[3] = 1;
        run_seq("corrupt3", 0);

        set_ideal(2);
        noack_wr[2] = 1;
        noack_rd[2] = 1;
        run_seq("noack08", 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                corrupt[i] = ($urandom_range(0, 3) == 0);
                noack_wr[i] = 0;
                noack_rd[i] = 0;
            end
            for (int k = 0; k < 16; k++) dly_tab[k] = $urandom_range(1, 4);
            if ($urandom_range(0, 2) == 0) begin
                int j = $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 1) noack_wr[j] = 1;
                else noack_rd[j] = 1;
            end
            spurious = ($urandom_range(0, 1) == 1);
            run_seq($sformatf("rnd%0d", r), 0);
        end

        set_ideal(3);
        abort_at("abort_wr5", 4, 0);
        set_ideal(2);
        run_seq("after_abort", 0);

        set_ideal(3);
        corrupt[1] = 1;
        abort_at("abort_rd", N + 4, 1);

        set_ideal(3);
        @(negedge clk);
        acc_k = 0;
        run = 1;
        wait_access("rst_mid", N + 3);
        #2 rst_n = 0;
        #1 check_val("rst_mid_outputs", all_outs(), 64'd0);
        run = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        check_val("rst_no_activity", 64'(acc_k), 64'(N + 4));
        check_val("rst_idle", 64'({req, busy, done}), 64'd0);
        set_ideal(2);
        run_seq("after_rst", 0);

        @(negedge clk);
        s_run = 1;
        b = 0;
        wraps = 0;
        prev = '0;
        @(negedge clk);
        while (!s_done && b < 20000) begin
            @(negedge clk);
            b++;
            if (s_err < prev) wraps++;
            prev = s_err;
        end
        check_val("sat_in_time", 64'(b < 20000), 64'd1);
        check_val("sat_err", 64'(s_err), 64'((2 * S_N > 255) ? 255 : 2 * S_N));
        check_val("sat_flags", 64'({s_busy, s_done, s_pass, s_tmo}), 64'b0101);
        check_val("sat_nowrap", 64'(wraps), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
